// File: rtl/llm_sn_mem_bridge.sv
// SN-side memory bridge for the upstream cache.
// Queues CHI-H requests in order, runs them one at a time against a
// valid/ready memory backend and returns in-order responses. A programmable
// timeout turns a lost backend response into an error completion.
module llm_sn_mem_bridge #(
    parameter int unsigned ADDR_W    = 48,
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned PRI_W     = 3,
    parameter int unsigned REQ_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [15:0]                  req_timeout,
    input  logic [ADDR_W-1:0]            sn_chi_req_addr,
    input  logic [DATA_W-1:0]            sn_chi_req_data,
    input  logic [7:0]                   sn_chi_req_size,
    input  logic                         sn_chi_req_snp,
    input  logic [31:0]                  sn_chi_req_pld,
    input  logic [PRI_W-1:0]             sn_chi_req_priority,
    input  logic                         sn_chi_req_valid,
    output logic                         sn_chi_req_ready,
    output logic [DATA_W-1:0]            sn_chi_resp_data,
    output logic                         sn_chi_resp_error,
    output logic [31:0]                  sn_chi_resp_pld,
    output logic                         sn_chi_resp_valid,
    input  logic                         sn_chi_resp_ready,
    output logic                         mem_req_valid,
    output logic                         mem_req_we,
    output logic [ADDR_W-1:0]            mem_req_addr,
    output logic [DATA_W-1:0]            mem_req_wdata,
    input  logic                         mem_req_ready,
    input  logic                         mem_rsp_valid,
    input  logic [DATA_W-1:0]            mem_rsp_rdata,
    input  logic                         mem_rsp_err,
    output logic [$clog2(REQ_DEPTH):0]   pending_count,
    output logic [7:0]                   timeout_count
);

    localparam int unsigned PTR_W = $clog2(REQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [7:0]        size;
        logic              snp;
        logic [31:0]       pld;
    } req_entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    req_entry_t        fifo_mem [REQ_DEPTH];
    req_entry_t        head;
    req_entry_t        push_entry;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    state_t            state;
    logic              stale;
    logic [15:0]       timer;
    logic              timer_hit;
    logic              rsp_live;

    // Size and priority are carried but have no effect on behaviour.
    logic              unused_fields;
    assign unused_fields = ^{sn_chi_req_priority, head.size};

    // Occupancy decode; ready is combinational from the registered count.
    assign full             = (pending_count == CNT_W'(REQ_DEPTH));
    assign empty            = (pending_count == CNT_W'(0));
    assign sn_chi_req_ready = !full && !rst;
    assign push             = sn_chi_req_valid && sn_chi_req_ready;
    assign pop              = (state == S_RESP) && sn_chi_resp_valid && sn_chi_resp_ready;
    assign head             = fifo_mem[rd_ptr];

    // A backend response while stale belongs to an abandoned access.
    assign rsp_live  = mem_rsp_valid && !stale;
    assign timer_hit = (req_timeout != 16'd0) && (timer == (req_timeout - 16'd1));

    always_comb begin
        push_entry      = '0;
        push_entry.addr = sn_chi_req_addr;
        push_entry.data = sn_chi_req_data;
        push_entry.size = sn_chi_req_size;
        push_entry.snp  = sn_chi_req_snp;
        push_entry.pld  = sn_chi_req_pld;
    end

    // FIFO storage; contents are qualified by the pointers so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            pending_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   pending_count <= pending_count + CNT_W'(1);
                2'b01:   pending_count <= pending_count - CNT_W'(1);
                default: pending_count <= pending_count;
            endcase
        end
    end

    // Request sequencer: issue, wait with timeout, and hold the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            stale             <= 1'b0;
            timer             <= '0;
            timeout_count     <= '0;
            mem_req_valid     <= 1'b0;
            mem_req_we        <= 1'b0;
            mem_req_addr      <= '0;
            mem_req_wdata     <= '0;
            sn_chi_resp_valid <= 1'b0;
            sn_chi_resp_data  <= '0;
            sn_chi_resp_error <= 1'b0;
            sn_chi_resp_pld   <= '0;
        end else begin
            if (stale && mem_rsp_valid) begin
                stale <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        if (head.snp) begin
                            state             <= S_RESP;
                            sn_chi_resp_valid <= 1'b1;
                            sn_chi_resp_data  <= '0;
                            sn_chi_resp_error <= 1'b0;
                            sn_chi_resp_pld   <= head.pld;
                        end else if (!stale) begin
                            state         <= S_ISSUE;
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= head.pld[0];
                            mem_req_addr  <= head.addr;
                            mem_req_wdata <= head.data;
                        end
                    end
                end

                S_ISSUE: begin
                    if (mem_req_ready) begin
                        state         <= S_WAIT;
                        mem_req_valid <= 1'b0;
                        timer         <= '0;
                    end
                end

                S_WAIT: begin
                    if (rsp_live) begin
                        state             <= S_RESP;
                        sn_chi_resp_valid <= 1'b1;
                        sn_chi_resp_data  <= head.pld[0] ? '0 : mem_rsp_rdata;
                        sn_chi_resp_error <= mem_rsp_err;
                        sn_chi_resp_pld   <= head.pld;
                    end else if (timer_hit) begin
                        state             <= S_RESP;
                        sn_chi_resp_valid <= 1'b1;
                        sn_chi_resp_data  <= '0;
                        sn_chi_resp_error <= 1'b1;
                        sn_chi_resp_pld   <= head.pld;
                        stale             <= 1'b1;
                        if (timeout_count != 8'hFF) begin
                            timeout_count <= timeout_count + 8'd1;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                S_RESP: begin
                    if (sn_chi_resp_ready) begin
                        state             <= S_IDLE;
                        sn_chi_resp_valid <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_llm_sn_mem_bridge.sv
// Directed self-checking bench for llm_sn_mem_bridge.
module tb_llm_sn_mem_bridge;

    localparam int unsigned ADDR_W    = 48;
    localparam int unsigned DATA_W    = 256;
    localparam int unsigned PRI_W     = 3;
    localparam int unsigned REQ_DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [15:0]          req_timeout = 16'd0;
    logic [ADDR_W-1:0]    sn_chi_req_addr = '0;
    logic [DATA_W-1:0]    sn_chi_req_data = '0;
    logic [7:0]           sn_chi_req_size = 8'd0;
    logic                 sn_chi_req_snp = 1'b0;
    logic [31:0]          sn_chi_req_pld = '0;
    logic [PRI_W-1:0]     sn_chi_req_priority = '0;
    logic                 sn_chi_req_valid = 1'b0;
    logic                 sn_chi_req_ready;
    logic [DATA_W-1:0]    sn_chi_resp_data;
    logic                 sn_chi_resp_error;
    logic [31:0]          sn_chi_resp_pld;
    logic                 sn_chi_resp_valid;
    logic                 sn_chi_resp_ready = 1'b1;
    logic                 mem_req_valid;
    logic                 mem_req_we;
    logic [ADDR_W-1:0]    mem_req_addr;
    logic [DATA_W-1:0]    mem_req_wdata;
    logic                 mem_req_ready = 1'b1;
    logic                 mem_rsp_valid = 1'b0;
    logic [DATA_W-1:0]    mem_rsp_rdata = '0;
    logic                 mem_rsp_err = 1'b0;
    logic [2:0]           pending_count;
    logic [7:0]           timeout_count;

    int total = 0;
    int bad   = 0;
    int mem_req_cycles = 0;

    llm_sn_mem_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRI_W(PRI_W), .REQ_DEPTH(REQ_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .req_timeout(req_timeout),
        .sn_chi_req_addr(sn_chi_req_addr), .sn_chi_req_data(sn_chi_req_data),
        .sn_chi_req_size(sn_chi_req_size), .sn_chi_req_snp(sn_chi_req_snp),
        .sn_chi_req_pld(sn_chi_req_pld), .sn_chi_req_priority(sn_chi_req_priority),
        .sn_chi_req_valid(sn_chi_req_valid), .sn_chi_req_ready(sn_chi_req_ready),
        .sn_chi_resp_data(sn_chi_resp_data), .sn_chi_resp_error(sn_chi_resp_error),
        .sn_chi_resp_pld(sn_chi_resp_pld), .sn_chi_resp_valid(sn_chi_resp_valid),
        .sn_chi_resp_ready(sn_chi_resp_ready),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .pending_count(pending_count), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    // Counts cycles in which a backend request is presented.
    always @(posedge clk) begin
        if (mem_req_valid) mem_req_cycles <= mem_req_cycles + 1;
    end

    // Read data the bench backend returns for a given address.
    function automatic logic [DATA_W-1:0] rd_pat(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = a[31:0] ^ 32'h5A5A_0000;
        return {8{w}};
    endfunction

    // Drive one request for one cycle, starting at the current negedge.
    task automatic push_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic s, input logic [31:0] p);
        sn_chi_req_addr  = a;
        sn_chi_req_data  = d;
        sn_chi_req_snp   = s;
        sn_chi_req_pld   = p;
        sn_chi_req_size  = 8'h20;
        sn_chi_req_priority = 3'd5;
        sn_chi_req_valid = 1'b1;
        @(negedge clk);
        sn_chi_req_valid = 1'b0;
    endtask

    // Backend that answers each accepted request one cycle later; returns the
    // first response seen on the SN side.
    task automatic run_backend(output logic ok, output logic [DATA_W-1:0] d,
                               output logic e, output logic [31:0] p);
        logic              pend;
        logic [ADDR_W-1:0] pa;
        pend = 1'b0; pa = '0; ok = 1'b0; d = '0; e = 1'b0; p = '0;
        for (int c = 0; c < 100 && !ok; c++) begin
            mem_rsp_valid = 1'b0;
            if (pend) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = rd_pat(pa);
                mem_rsp_err   = 1'b0;
                pend = 1'b0;
            end
            if (mem_req_valid && mem_req_ready) begin
                pend = 1'b1;
                pa   = mem_req_addr;
            end
            if (sn_chi_resp_valid) begin
                ok = 1'b1;
                d  = sn_chi_resp_data;
                e  = sn_chi_resp_error;
                p  = sn_chi_resp_pld;
            end
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (sn_chi_req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got %0b want 0", sn_chi_req_ready); end
        total++; if (sn_chi_resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got %0b want 0", sn_chi_resp_valid); end
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_req_valid got %0b want 0", mem_req_valid); end
        total++; if (pending_count !== 3'd0) begin bad++; $display("FAIL rst_pending got %0d want 0", pending_count); end
        total++; if (timeout_count !== 8'd0) begin bad++; $display("FAIL rst_timeouts got %0d want 0", timeout_count); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (sn_chi_req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got %0b want 1", sn_chi_req_ready); end
    endtask

    task automatic test_snoop();
        int m0;
        m0 = mem_req_cycles;
        push_one(48'h0, '0, 1'b1, 32'h0000_0010);
        total++; if (sn_chi_resp_valid !== 1'b0) begin bad++; $display("FAIL snp_early_valid got %0b want 0", sn_chi_resp_valid); end
        total++; if (pending_count !== 3'd1) begin bad++; $display("FAIL snp_pending got %0d want 1", pending_count); end
        @(negedge clk);
        total++; if (sn_chi_resp_valid !== 1'b1) begin bad++; $display("FAIL snp_valid got %0b want 1", sn_chi_resp_valid); end
        total++; if (sn_chi_resp_data !== '0) begin bad++; $display("FAIL snp_data got %h want 0", sn_chi_resp_data); end
        total++; if (sn_chi_resp_error !== 1'b0) begin bad++; $display("FAIL snp_error got %0b want 0", sn_chi_resp_error); end
        total++; if (sn_chi_resp_pld !== 32'h10) begin bad++; $display("FAIL snp_pld got %h want 10", sn_chi_resp_pld); end
        @(negedge clk);
        total++; if (sn_chi_resp_valid !== 1'b0) begin bad++; $display("FAIL snp_drop got %0b want 0", sn_chi_resp_valid); end
        total++; if (pending_count !== 3'd0) begin bad++; $display("FAIL snp_pop got %0d want 0", pending_count); end
        total++; if (mem_req_cycles !== m0) begin bad++; $display("FAIL snp_no_mem got %0d want %0d", mem_req_cycles, m0); end
    endtask

    task automatic test_read();
        push_one(48'h1000, '0, 1'b0, 32'h0);
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL rd_early_req got %0b want 0", mem_req_valid); end
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL rd_req_valid got %0b want 1", mem_req_valid); end
        total++; if (mem_req_we !== 1'b0) begin bad++; $display("FAIL rd_we got %0b want 0", mem_req_we); end
        total++; if (mem_req_addr !== 48'h1000) begin bad++; $display("FAIL rd_addr got %h want 1000", mem_req_addr); end
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL rd_req_drop got %0b want 0", mem_req_valid); end
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = {32{8'hA5}}; mem_rsp_err = 1'b0;
        total++; if (sn_chi_resp_valid !== 1'b0) begin bad++; $display("FAIL rd_early_resp got %0b want 0", sn_chi_resp_valid); end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        total++; if (sn_chi_resp_valid !== 1'b1) begin bad++; $display("FAIL rd_resp_valid got %0b want 1", sn_chi_resp_valid); end
        total++; if (sn_chi_resp_data !== {32{8'hA5}}) begin bad++; $display("FAIL rd_data got %h want a5..a5", sn_chi_resp_data); end
        total++; if (sn_chi_resp_error !== 1'b0) begin bad++; $display("FAIL rd_error got %0b want 0", sn_chi_resp_error); end
        @(negedge clk);
        total++; if (pending_count !== 3'd0) begin bad++; $display("FAIL rd_pop got %0d want 0", pending_count); end
    endtask

    task automatic test_full_backpressure();
        logic [ADDR_W-1:0] exp_addr  [4];
        logic [31:0]       exp_pld   [4];
        logic [DATA_W-1:0] exp_wdata [4];
        logic [DATA_W-1:0] exp_data  [4];
        logic              pend;
        logic [ADDR_W-1:0] pa;
        int                issued;
        int                got;
        for (int i = 0; i < 4; i++) begin
            exp_addr[i]  = 48'h2000 + 48'(i * 64);
            exp_pld[i]   = 32'h100 + 32'(i);
            exp_wdata[i] = {8{32'h1111_0000 + 32'(i)}};
            exp_data[i]  = exp_pld[i][0] ? '0 : rd_pat(exp_addr[i]);
        end
        mem_req_ready = 1'b0;
        sn_chi_resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sn_chi_req_addr  = 48'h2000 + 48'(i * 64);
            sn_chi_req_data  = {8{32'h1111_0000 + 32'(i)}};
            sn_chi_req_pld   = 32'h100 + 32'(i);
            sn_chi_req_snp   = 1'b0;
            sn_chi_req_valid = 1'b1;
            total++; if (sn_chi_req_ready !== 1'(i < 4)) begin bad++; $display("FAIL full_ready_%0d got %0b want %0b", i, sn_chi_req_ready, 1'(i < 4)); end
            @(negedge clk);
        end
        sn_chi_req_valid = 1'b0;
        total++; if (sn_chi_req_ready !== 1'b0) begin bad++; $display("FAIL full_ready got %0b want 0", sn_chi_req_ready); end
        total++; if (pending_count !== 3'd4) begin bad++; $display("FAIL full_pending got %0d want 4", pending_count); end
        total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL full_req_held got %0b want 1", mem_req_valid); end
        @(negedge clk);
        mem_req_ready = 1'b1;
        sn_chi_resp_ready = 1'b1;
        pend = 1'b0; pa = '0; issued = 0; got = 0;
        for (int c = 0; c < 200 && got < 4; c++) begin
            mem_rsp_valid = 1'b0;
            if (pend) begin
                mem_rsp_valid = 1'b1; mem_rsp_rdata = rd_pat(pa); mem_rsp_err = 1'b0;
                pend = 1'b0;
            end
            if (mem_req_valid && issued < 4) begin
                total++; if (mem_req_addr !== exp_addr[issued]) begin bad++; $display("FAIL bp_addr_%0d got %h want %h", issued, mem_req_addr, exp_addr[issued]); end
                total++; if (mem_req_we !== exp_pld[issued][0]) begin bad++; $display("FAIL bp_we_%0d got %0b want %0b", issued, mem_req_we, exp_pld[issued][0]); end
                total++; if (mem_req_wdata !== exp_wdata[issued]) begin bad++; $display("FAIL bp_wdata_%0d got %h want %h", issued, mem_req_wdata, exp_wdata[issued]); end
                pend = 1'b1; pa = mem_req_addr; issued++;
            end
            if (sn_chi_resp_valid) begin
                total++; if (sn_chi_resp_pld !== exp_pld[got]) begin bad++; $display("FAIL bp_pld_%0d got %h want %h", got, sn_chi_resp_pld, exp_pld[got]); end
                total++; if (sn_chi_resp_data !== exp_data[got]) begin bad++; $display("FAIL bp_data_%0d got %h want %h", got, sn_chi_resp_data, exp_data[got]); end
                total++; if (sn_chi_resp_error !== 1'b0) begin bad++; $display("FAIL bp_err_%0d got %0b want 0", got, sn_chi_resp_error); end
                got++;
            end
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0;
        total++; if (got !== 4) begin bad++; $display("FAIL bp_count got %0d want 4", got); end
        total++; if (pending_count !== 3'd0) begin bad++; $display("FAIL bp_drain got %0d want 0", pending_count); end
    endtask

    task automatic test_timeout_stale();
        logic              ok;
        logic [DATA_W-1:0] d;
        logic              e;
        logic [31:0]       p;
        req_timeout = 16'd8;
        push_one(48'h3000, '0, 1'b0, 32'h20);
        repeat (9) @(negedge clk);
        total++; if (sn_chi_resp_valid !== 1'b0) begin bad++; $display("FAIL to_early got %0b want 0", sn_chi_resp_valid); end
        @(negedge clk);
        total++; if (sn_chi_resp_valid !== 1'b1) begin bad++; $display("FAIL to_valid got %0b want 1", sn_chi_resp_valid); end
        total++; if (sn_chi_resp_error !== 1'b1) begin bad++; $display("FAIL to_error got %0b want 1", sn_chi_resp_error); end
        total++; if (sn_chi_resp_data !== '0) begin bad++; $display("FAIL to_data got %h want 0", sn_chi_resp_data); end
        total++; if (sn_chi_resp_pld !== 32'h20) begin bad++; $display("FAIL to_pld got %h want 20", sn_chi_resp_pld); end
        total++; if (timeout_count !== 8'd1) begin bad++; $display("FAIL to_count got %0d want 1", timeout_count); end
        @(negedge clk);
        push_one(48'h3100, '0, 1'b0, 32'h30);
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL stale_block0 got %0b want 0", mem_req_valid); end
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL stale_block1 got %0b want 0", mem_req_valid); end
        mem_rsp_valid = 1'b1; mem_rsp_rdata = {DATA_W{1'b1}}; mem_rsp_err = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        total++; if (sn_chi_resp_valid !== 1'b0) begin bad++; $display("FAIL stale_discard got %0b want 0", sn_chi_resp_valid); end
        run_backend(ok, d, e, p);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL stale_next_done got %0b want 1", ok); end
        total++; if (d !== rd_pat(48'h3100)) begin bad++; $display("FAIL stale_next_data got %h want %h", d, rd_pat(48'h3100)); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL stale_next_err got %0b want 0", e); end
        total++; if (p !== 32'h30) begin bad++; $display("FAIL stale_next_pld got %h want 30", p); end
        total++; if (timeout_count !== 8'd1) begin bad++; $display("FAIL stale_count got %0d want 1", timeout_count); end
    endtask

    task automatic test_race();
        req_timeout = 16'd8;
        push_one(48'h4000, '0, 1'b0, 32'h40);
        repeat (9) @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = rd_pat(48'h4000); mem_rsp_err = 1'b0;
        total++; if (sn_chi_resp_valid !== 1'b0) begin bad++; $display("FAIL race_early got %0b want 0", sn_chi_resp_valid); end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        total++; if (sn_chi_resp_valid !== 1'b1) begin bad++; $display("FAIL race_valid got %0b want 1", sn_chi_resp_valid); end
        total++; if (sn_chi_resp_error !== 1'b0) begin bad++; $display("FAIL race_error got %0b want 0", sn_chi_resp_error); end
        total++; if (sn_chi_resp_data !== rd_pat(48'h4000)) begin bad++; $display("FAIL race_data got %h want %h", sn_chi_resp_data, rd_pat(48'h4000)); end
        total++; if (timeout_count !== 8'd1) begin bad++; $display("FAIL race_count got %0d want 1", timeout_count); end
        @(negedge clk);
        total++; if (pending_count !== 3'd0) begin bad++; $display("FAIL race_pop got %0d want 0", pending_count); end
    endtask

    task automatic test_reset_mid();
        logic              ok;
        logic [DATA_W-1:0] d;
        logic              e;
        logic [31:0]       p;
        req_timeout = 16'd0;
        push_one(48'h6000, '0, 1'b0, 32'h60);
        push_one(48'h6040, '0, 1'b0, 32'h61);
        push_one(48'h6080, '0, 1'b1, 32'h62);
        total++; if (pending_count !== 3'd3) begin bad++; $display("FAIL mid_pending got %0d want 3", pending_count); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (sn_chi_req_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got %0b want 0", sn_chi_req_ready); end
        total++; if (pending_count !== 3'd0) begin bad++; $display("FAIL mid_rst_pending got %0d want 0", pending_count); end
        total++; if (timeout_count !== 8'd0) begin bad++; $display("FAIL mid_timeouts got %0d want 0", timeout_count); end
        total++; if (mem_req_addr !== '0) begin bad++; $display("FAIL mid_addr got %h want 0", mem_req_addr); end
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL mid_req_valid got %0b want 0", mem_req_valid); end
        total++; if (sn_chi_resp_valid !== 1'b0) begin bad++; $display("FAIL mid_resp_valid got %0b want 0", sn_chi_resp_valid); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (sn_chi_req_ready !== 1'b1) begin bad++; $display("FAIL mid_post_ready got %0b want 1", sn_chi_req_ready); end
        total++; if (pending_count !== 3'd0) begin bad++; $display("FAIL mid_post_pending got %0d want 0", pending_count); end
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL mid_idle got %0b want 0", mem_req_valid); end
        push_one(48'h7000, '0, 1'b0, 32'h70);
        run_backend(ok, d, e, p);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL mid_new_done got %0b want 1", ok); end
        total++; if (d !== rd_pat(48'h7000)) begin bad++; $display("FAIL mid_new_data got %h want %h", d, rd_pat(48'h7000)); end
        total++; if (p !== 32'h70) begin bad++; $display("FAIL mid_new_pld got %h want 70", p); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL mid_new_err got %0b want 0", e); end
    endtask

    initial begin
        test_reset();
        test_snoop();
        test_read();
        test_full_backpressure();
        test_timeout_stale();
        test_race();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
